// File: rtl/set_driver.sv
// Command sequencer for the SET engine: buffers host commands in a small FIFO,
// issues them one at a time, and returns each result (or a timeout) in order.
module set_driver #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [23:0] cmd_central,
   input  logic [11:0] cmd_radius,
   input  logic [1:0]  cmd_mode,
   input  logic [3:0]  cmd_tag,
   output logic        set_en,
   output logic [23:0] set_central,
   output logic [11:0] set_radius,
   output logic [1:0]  set_mode,
   input  logic        set_busy,
   input  logic        set_valid,
   input  logic [7:0]  set_candidate,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_candidate,
   output logic [3:0]  rsp_tag,
   output logic        rsp_timeout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 24 + 12 + 2 + 4;
   localparam logic [9:0] TMO_LIM = 10'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

   state_t      state_q;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        fifo_full, fifo_empty, push, pop;
   logic [EW-1:0] head;

   logic        set_en_q;
   logic [23:0] set_central_q;
   logic [11:0] set_radius_q;
   logic [1:0]  set_mode_q;
   logic [3:0]  tag_q;
   logic [9:0]  tmo_cnt_q, tmo_cnt_d;
   logic        timeout_hit;
   logic        rsp_valid_q, rsp_timeout_q;
   logic [7:0]  rsp_candidate_q;
   logic [3:0]  rsp_tag_q;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && !fifo_full;
   assign pop        = (state_q == IDLE) && !fifo_empty && !rsp_valid_q;
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {cmd_central, cmd_radius, cmd_mode, cmd_tag};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign tmo_cnt_d   = tmo_cnt_q + 10'd1;
   assign timeout_hit = (tmo_cnt_d == TMO_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         set_en_q        <= 1'b0;
         set_central_q   <= '0;
         set_radius_q    <= '0;
         set_mode_q      <= '0;
         tag_q           <= '0;
         tmo_cnt_q       <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_candidate_q <= '0;
         rsp_tag_q       <= '0;
         rsp_timeout_q   <= 1'b0;
      end else begin
         set_en_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  {set_central_q, set_radius_q, set_mode_q, tag_q} <= head;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               set_en_q  <= 1'b1;
               tmo_cnt_q <= '0;
               state_q   <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // set_valid may still be high from the previous command here.
               tmo_cnt_q <= tmo_cnt_d;
               if (timeout_hit) begin
                  rsp_valid_q     <= 1'b1;
                  rsp_candidate_q <= '0;
                  rsp_timeout_q   <= 1'b1;
                  rsp_tag_q       <= tag_q;
                  state_q         <= RESP;
               end else if (set_busy) begin
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               tmo_cnt_q <= tmo_cnt_d;
               if (!set_busy && set_valid) begin
                  rsp_valid_q     <= 1'b1;
                  rsp_candidate_q <= set_candidate;
                  rsp_timeout_q   <= 1'b0;
                  rsp_tag_q       <= tag_q;
                  state_q         <= RESP;
               end else if (timeout_hit) begin
                  rsp_valid_q     <= 1'b1;
                  rsp_candidate_q <= '0;
                  rsp_timeout_q   <= 1'b1;
                  rsp_tag_q       <= tag_q;
                  state_q         <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign set_en        = set_en_q;
   assign set_central   = set_central_q;
   assign set_radius    = set_radius_q;
   assign set_mode      = set_mode_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_candidate = rsp_candidate_q;
   assign rsp_tag       = rsp_tag_q;
   assign rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_set_driver.sv
// Scoreboard bench for set_driver with a behavioural SET engine that counts
// lattice points (1..8 grid) inside the requested circle combination.
module tb_set_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [23:0] cmd_central = '0;
   logic [11:0] cmd_radius = '0;
   logic [1:0]  cmd_mode = '0;
   logic [3:0]  cmd_tag = '0;
   logic        set_en;
   logic [23:0] set_central;
   logic [11:0] set_radius;
   logic [1:0]  set_mode;
   logic        set_busy = 1'b0;
   logic        set_valid = 1'b0;
   logic [7:0]  set_candidate = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [7:0]  rsp_candidate;
   logic [3:0]  rsp_tag;
   logic        rsp_timeout;

   set_driver #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_central(cmd_central), .cmd_radius(cmd_radius),
      .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
      .set_en(set_en), .set_central(set_central),
      .set_radius(set_radius), .set_mode(set_mode),
      .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_candidate(rsp_candidate), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] c;
      logic [11:0] r;
      logic [1:0]  m;
   } cmd_t;

   cmd_t        cmd_q [$];
   logic [12:0] rsp_q [$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          se_cyc = 0;
   int          lat_start = 0;
   bit          lat_arm = 0, lat_pend = 0;
   bit          eng_dead = 0;
   bit          outstanding = 0;
   bit          prev_set_en = 0, prev_rsp_valid = 0;
   int          eng_cnt = 0;
   logic [7:0]  eng_res = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic bit in_circ(int x, int y, logic [3:0] cx, logic [3:0] cy, logic [3:0] r);
      int dx = x - int'(cx);
      int dy = y - int'(cy);
      return (dx * dx + dy * dy) <= int'(r) * int'(r);
   endfunction

   function automatic logic [7:0] calc(logic [23:0] c, logic [11:0] r, logic [1:0] m);
      int cnt = 0;
      for (int x = 1; x <= 8; x++) begin
         for (int y = 1; y <= 8; y++) begin
            bit a = in_circ(x, y, c[23:20], c[19:16], r[11:8]);
            bit b = in_circ(x, y, c[15:12], c[11:8],  r[7:4]);
            bit k = in_circ(x, y, c[7:4],   c[3:0],   r[3:0]);
            bit hit;
            case (m)
               2'd0:    hit = a;
               2'd1:    hit = a && b;
               2'd2:    hit = a ^ b;
               default: hit = (int'(a) + int'(b) + int'(k)) == 2;
            endcase
            if (hit) cnt++;
         end
      end
      return 8'(cnt);
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   // SET engine: stale valid for 2 cycles, busy for 3, then valid with result.
   always @(negedge clk) begin
      if (rst) begin
         set_busy = 0; set_valid = 0; set_candidate = '0; eng_cnt = 0;
      end else if (set_en) begin
         if (!eng_dead) begin
            eng_cnt = 6;
            eng_res = calc(set_central, set_radius, set_mode);
         end
      end else if (eng_cnt != 0) begin
         eng_cnt = eng_cnt - 1;
         if (eng_cnt == 3) begin
            set_busy = 1; set_valid = 0;
         end else if (eng_cnt == 0) begin
            set_busy = 0; set_valid = 1; set_candidate = eng_res;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid && cmd_ready) begin
            cmd_q.push_back({cmd_central, cmd_radius, cmd_mode});
            rsp_q.push_back(eng_dead ? {8'd0, cmd_tag, 1'b1}
                                     : {calc(cmd_central, cmd_radius, cmd_mode), cmd_tag, 1'b0});
            if (lat_arm) begin
               lat_arm = 0; lat_pend = 1; lat_start = cyc;
            end
         end
         if (set_en) begin
            check("en_width", 64'(prev_set_en), 64'd0);
            check("one_outstanding", 64'(outstanding), 64'd0);
            if (cmd_q.size() == 0) begin
               check("spurious_set_en", 64'd1, 64'd0);
            end else begin
               check("set_fields", {set_central, set_radius, set_mode}, 64'(cmd_q[0]));
               void'(cmd_q.pop_front());
            end
            if (lat_pend) begin
               check("issue_latency", 64'(cyc - lat_start), 64'd3);
               lat_pend = 0;
            end
            outstanding = 1;
            se_cyc = cyc;
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               check("spurious_rsp", 64'd1, 64'd0);
            end else begin
               check("rsp", {rsp_candidate, rsp_tag, rsp_timeout}, 64'(rsp_q[0]));
               if (!prev_rsp_valid && rsp_q[0][0])
                  check("timeout_latency",
                        64'((cyc - se_cyc) >= 14 && (cyc - se_cyc) <= 18), 64'd1);
               if (rsp_ready) begin
                  $display("rsp tag=%0d cand=%0d timeout=%0b", rsp_tag, rsp_candidate, rsp_timeout);
                  void'(rsp_q.pop_front());
                  outstanding = 0;
               end
            end
         end
      end
      prev_set_en    = set_en;
      prev_rsp_valid = rsp_valid;
   end

   task automatic push_cmd(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input logic [3:0] t);
      int  n = 0;
      bit  acc = 0;
      cmd_valid = 1; cmd_central = c; cmd_radius = r; cmd_mode = m; cmd_tag = t;
      do begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) check("push_timeout", 64'd0, 64'd1);
      cmd_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((cmd_q.size() != 0 || rsp_q.size() != 0 || rsp_valid) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", 64'(cmd_q.size() + rsp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      check(tag, {cmd_ready, set_en, set_central, set_radius, set_mode,
                  rsp_valid, rsp_candidate, rsp_tag, rsp_timeout}, {1'b1, 53'd0});
   endtask

   initial begin
      int n;
      #2 rst = 1;
      #1 check_reset_outs("reset_state");
      repeat (2) @(posedge clk);
      #1 rst = 0;
      repeat (2) @(posedge clk); #1;

      lat_arm = 1;
      push_cmd(24'h440000, 12'h200, 2'd0, 4'd3);
      drain();
      push_cmd(24'h335500, 12'h220, 2'd1, 4'd5);
      drain();
      for (int i = 0; i < 4; i++)
         push_cmd(24'($urandom), 12'($urandom), 2'(i), 4'(i + 6));
      drain();

      // Burst with host stalled: one command in flight, four fill the FIFO.
      rsp_ready = 0;
      for (int i = 0; i < 5; i++)
         push_cmd({4'(i + 2), 4'd3, 4'd5, 4'd4, 4'd2, 4'd6}, 12'h332, 2'(i), 4'(i + 1));
      @(negedge clk);
      check("fifo_full_ready", 64'(cmd_ready), 64'd0);
      repeat (12) @(posedge clk);
      #1 rsp_ready = 1;
      drain();

      eng_dead = 1;
      push_cmd(24'h444444, 12'h111, 2'd0, 4'd9);
      drain();
      eng_dead = 0;
      push_cmd(24'h555555, 12'h321, 2'd2, 4'd10);
      drain();

      // Reset while the engine is busy, with a second command still queued.
      push_cmd(24'h440000, 12'h300, 2'd0, 4'd11);
      push_cmd(24'h220000, 12'h100, 2'd0, 4'd12);
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!set_busy && n < 100);
      check("busy_seen", 64'(set_busy), 64'd1);
      @(posedge clk); #1;
      rst = 1;
      #1 check_reset_outs("reset_mid_cmd");
      cmd_q.delete(); rsp_q.delete(); outstanding = 0; lat_pend = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      repeat (10) @(posedge clk); #1;
      check("idle_after_reset", {cmd_ready, rsp_valid}, 2'b10);

      lat_arm = 1;
      push_cmd(24'h660000, 12'h300, 2'd0, 4'd13);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=%0d exp=0", cyc);
      $fatal(1);
   end

endmodule
